// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// It shows a per-frame snapshot of four BCD digits and can blink the selected digit in adjust mode.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk_c,
  input  logic       reset_c,
  input  logic       ADJ,
  input  logic [1:0] SEL,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned BLK_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       shadow_q [4];
  logic [3:0]       shadow_d [4];
  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_start_q, frame_start_d;

  logic       tick;
  logic       blank;
  logic [3:0] digit;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;

    shadow_d      = shadow_q;
    frame_start_d = 1'b0;
    if (tick && idx_q == 2'd3) begin
      shadow_d[0]   = sec_ones;
      shadow_d[1]   = sec_tens;
      shadow_d[2]   = min_ones;
      shadow_d[3]   = min_tens;
      frame_start_d = 1'b1;
    end

    // Holding the blink state at zero while ADJ is low makes every ADJ rise start visible.
    blink_cnt_d = '0;
    blink_ph_d  = 1'b0;
    if (ADJ) begin
      if (blink_cnt_q == BLK_LAST) begin
        blink_cnt_d = '0;
        blink_ph_d  = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLK_W'(1);
        blink_ph_d  = blink_ph_q;
      end
    end

    digit = shadow_q[idx_q];
    case (digit)
      4'd0:    seg_d = 7'h40;
      4'd1:    seg_d = 7'h79;
      4'd2:    seg_d = 7'h24;
      4'd3:    seg_d = 7'h30;
      4'd4:    seg_d = 7'h19;
      4'd5:    seg_d = 7'h12;
      4'd6:    seg_d = 7'h02;
      4'd7:    seg_d = 7'h78;
      4'd8:    seg_d = 7'h00;
      4'd9:    seg_d = 7'h10;
      default: seg_d = 7'h7F;
    endcase

    dp_d  = (idx_q != 2'd2);
    blank = ADJ && blink_ph_q && (idx_q == SEL);
    // The first cycle of every slot is blanked so the previous digit does not ghost.
    an_d  = ((cnt_q == '0) || blank) ? 4'hF : ~(4'b0001 << idx_q);
  end

  always_ff @(posedge clk_c) begin
    if (reset_c) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_q      <= '{default: '0};
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      an_q          <= 4'hF;
      seg_q         <= 7'h7F;
      dp_q          <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule
